// File: rtl/bg_scroll_renderer.sv
// Scrolling background renderer: display coords -> scaled/wrapped source address
// -> palette lookup, as a 4-stage pix_en-gated pipeline.
`timescale 1ns/1ps
module bg_scroll_renderer #(
  parameter int SRC_W      = 320,
  parameter int SRC_H      = 240,
  parameter int SCALE_LOG2 = 1,
  parameter int IDX_W      = 4,
  parameter int ADDR_W     = 17
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pix_en,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        scroll_x_in,
  input  logic [9:0]        scroll_y_in,
  input  logic              scroll_we,
  input  logic              pal_we,
  input  logic [IDX_W-1:0]  pal_addr,
  input  logic [23:0]       pal_data,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [IDX_W-1:0]  mem_data,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              pix_valid
);

  localparam int                PAL_N = 2 ** IDX_W;
  localparam logic [10:0]       W11   = 11'(SRC_W);
  localparam logic [10:0]       H11   = 11'(SRC_H);
  localparam logic [ADDR_W-1:0] W_A   = ADDR_W'(SRC_W);

  function automatic logic [7:0] grey_level(input int i);
    return 8'((i * 255) / (PAL_N - 1));
  endfunction

  logic [9:0]  shadow_x, shadow_y, active_x, active_y;
  logic [9:0]  shadow_x_nxt, shadow_y_nxt;

  logic [9:0]  xs_c, ys_c;
  logic        in_range_c;
  logic [9:0]  xs0, ys0;
  logic        blank0, inr0;

  logic [10:0] sum_x, sum_y, sx, sy;
  logic [ADDR_W-1:0] addr_c;
  logic        blank1, inr1;

  logic [IDX_W-1:0] idx2;
  logic        blank2, inr2;

  logic [23:0] palette [PAL_N];

  // Out-of-range scroll writes are ignored so the wrap logic only ever needs one subtraction
  always_comb begin
    shadow_x_nxt = shadow_x;
    shadow_y_nxt = shadow_y;
    if (scroll_we && ({1'b0, scroll_x_in} < W11)) shadow_x_nxt = scroll_x_in;
    if (scroll_we && ({1'b0, scroll_y_in} < H11)) shadow_y_nxt = scroll_y_in;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      shadow_x <= '0;
      shadow_y <= '0;
      active_x <= '0;
      active_y <= '0;
    end else begin
      shadow_x <= shadow_x_nxt;
      shadow_y <= shadow_y_nxt;
      if (frame_start) begin
        active_x <= shadow_x_nxt;
        active_y <= shadow_y_nxt;
      end
    end
  end

  always_comb begin
    xs_c       = DrawX >> SCALE_LOG2;
    ys_c       = DrawY >> SCALE_LOG2;
    in_range_c = ({1'b0, xs_c} < W11) && ({1'b0, ys_c} < H11);
  end

  // Both operands are below the source size, so a single conditional subtract wraps
  always_comb begin
    sum_x  = {1'b0, xs0} + {1'b0, active_x};
    sum_y  = {1'b0, ys0} + {1'b0, active_y};
    sx     = (sum_x >= W11) ? (sum_x - W11) : sum_x;
    sy     = (sum_y >= H11) ? (sum_y - H11) : sum_y;
    addr_c = ADDR_W'(sy) * W_A + ADDR_W'(sx);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      xs0       <= '0;
      ys0       <= '0;
      blank0    <= 1'b0;
      inr0      <= 1'b0;
      mem_addr  <= '0;
      blank1    <= 1'b0;
      inr1      <= 1'b0;
      idx2      <= '0;
      blank2    <= 1'b0;
      inr2      <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      pix_valid <= 1'b0;
    end else if (pix_en) begin
      xs0      <= xs_c;
      ys0      <= ys_c;
      blank0   <= blank;
      inr0     <= in_range_c;
      mem_addr <= addr_c;
      blank1   <= blank0;
      inr1     <= inr0;
      idx2     <= mem_data;
      blank2   <= blank1;
      inr2     <= inr1;
      if (blank2 && inr2) begin
        {red, green, blue} <= palette[idx2];
        pix_valid          <= 1'b1;
      end else begin
        {red, green, blue} <= '0;
        pix_valid          <= 1'b0;
      end
    end
  end

  // Palette writes ignore pix_en; a same-edge read in the output stage sees the old entry
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < PAL_N; i++) begin
        palette[i] <= {3{grey_level(i)}};
      end
    end else if (pal_we) begin
      palette[pal_addr] <= pal_data;
    end
  end

endmodule

// File: tb/tb_bg_scroll_renderer.sv
// Randomized bench for bg_scroll_renderer: a queue-based pixel model with modulo
// wrapping and a shadow palette predicts every output and source address.
`timescale 1ns/1ps
module tb_bg_scroll_renderer;

  localparam int SRC_W      = 320;
  localparam int SRC_H      = 240;
  localparam int SCALE_LOG2 = 1;
  localparam int IDX_W      = 4;
  localparam int ADDR_W     = 17;
  localparam int PAL_N      = 2 ** IDX_W;

  logic              Clk = 1'b0;
  logic              Reset, pix_en, blank, frame_start, scroll_we, pal_we;
  logic [9:0]        DrawX, DrawY, scroll_x_in, scroll_y_in;
  logic [IDX_W-1:0]  pal_addr, mem_data;
  logic [23:0]       pal_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        red, green, blue;
  logic              pix_valid;

  logic              force_mem;
  logic [IDX_W-1:0]  force_val;

  bg_scroll_renderer #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE_LOG2(SCALE_LOG2), .IDX_W(IDX_W), .ADDR_W(ADDR_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .pix_en(pix_en), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .frame_start(frame_start), .scroll_x_in(scroll_x_in),
    .scroll_y_in(scroll_y_in), .scroll_we(scroll_we), .pal_we(pal_we),
    .pal_addr(pal_addr), .pal_data(pal_data), .mem_addr(mem_addr), .mem_data(mem_data),
    .red(red), .green(green), .blue(blue), .pix_valid(pix_valid)
  );

  always #5 Clk = ~Clk;

  // Source image content: a fixed hash of the address, or a forced index
  assign mem_data = force_mem ? force_val
                              : IDX_W'(mem_addr ^ (mem_addr >> 4) ^ (mem_addr >> 9));

  typedef struct {
    int xs;
    int ys;
    bit inr;
    bit vis;
    int addr;
    int idx;
  } pix_t;

  pix_t        pq[$];
  int          sh_x, sh_y, act_x, act_y;
  logic [23:0] pal_m [PAL_N];
  logic [23:0] exp_rgb;
  logic        exp_valid;
  int          tests, fails;

  function automatic int memModel(input int a, input bit f, input int fv);
    return f ? fv : ((a ^ (a >> 4) ^ (a >> 9)) & (PAL_N - 1));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    pix_t bub;
    bub = '{default: 0};
    pq.delete();
    repeat (4) pq.push_back(bub);
    sh_x = 0; sh_y = 0; act_x = 0; act_y = 0;
    for (int i = 0; i < PAL_N; i++) pal_m[i] = {3{8'((i * 255) / (PAL_N - 1))}};
    exp_rgb   = '0;
    exp_valid = 1'b0;
  endtask

  // Queue slots: [0]=output stage, [1]=memory-data stage, [2]=address stage, [3]=input stage
  task automatic modelEdge();
    int nx, ny;
    if (Reset) begin
      modelReset();
      return;
    end
    if (pix_en) begin
      pix_t p;
      p       = '{default: 0};
      p.xs    = int'(DrawX) >> SCALE_LOG2;
      p.ys    = int'(DrawY) >> SCALE_LOG2;
      p.inr   = (p.xs < SRC_W) && (p.ys < SRC_H);
      p.vis   = blank && p.inr;
      pq.push_back(p);
      void'(pq.pop_front());
      pq[2].addr = ((pq[2].ys + act_y) % SRC_H) * SRC_W + ((pq[2].xs + act_x) % SRC_W);
      pq[1].idx  = memModel(pq[1].addr, force_mem, int'(force_val));
      exp_valid  = pq[0].vis;
      exp_rgb    = pq[0].vis ? pal_m[pq[0].idx] : 24'h0;
    end
    nx = (scroll_we && int'(scroll_x_in) < SRC_W) ? int'(scroll_x_in) : sh_x;
    ny = (scroll_we && int'(scroll_y_in) < SRC_H) ? int'(scroll_y_in) : sh_y;
    sh_x = nx;
    sh_y = ny;
    if (frame_start) begin
      act_x = nx;
      act_y = ny;
    end
    if (pal_we) pal_m[pal_addr] = pal_data;
  endtask

  task automatic applyStimulus(input logic rst, input logic pe, input logic [9:0] dx,
                               input logic [9:0] dy, input logic bl, input logic fs,
                               input logic swe, input logic [9:0] sxi, input logic [9:0] syi,
                               input logic pwe, input logic [IDX_W-1:0] pa,
                               input logic [23:0] pd);
    @(negedge Clk);
    Reset = rst; pix_en = pe; DrawX = dx; DrawY = dy; blank = bl; frame_start = fs;
    scroll_we = swe; scroll_x_in = sxi; scroll_y_in = syi;
    pal_we = pwe; pal_addr = pa; pal_data = pd;
    modelEdge();
    @(posedge Clk);
    #1;
    checkOutput("rgb", {8'h0, red, green, blue}, {8'h0, exp_rgb});
    checkOutput("pix_valid", 32'(pix_valid), 32'(exp_valid));
    if (pq[2].inr) checkOutput("mem_addr", 32'(mem_addr), 32'(pq[2].addr));
  endtask

  task automatic pixelStep(input logic pe, input logic [9:0] dx, input logic [9:0] dy,
                           input logic bl);
    applyStimulus(1'b0, pe, dx, dy, bl, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, '0, 24'h0);
  endtask

  initial begin
    tests = 0; fails = 0;
    force_mem = 1'b0; force_val = '0;
    Reset = 1'b1; pix_en = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b0;
    frame_start = 1'b0; scroll_we = 1'b0; scroll_x_in = '0; scroll_y_in = '0;
    pal_we = 1'b0; pal_addr = '0; pal_data = '0;
    modelReset();

    repeat (2) applyStimulus(1'b1, 1'b1, 10'd7, 10'd7, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0,
                             1'b0, '0, 24'h0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset_rgb", {8'h0, red, green, blue}, 32'h0);
    checkOutput("reset_valid", 32'(pix_valid), 32'd0);

    // Basic pixel with pix_en every second clock
    for (int c = 0; c < 8; c++) begin
      pixelStep(1'(c % 2), 10'd5, 10'd3, 1'b1);
      if (c == 3) checkOutput("addr_322", 32'(mem_addr), 32'd322);
      if (c == 7) checkOutput("rgb_after_4", {8'h0, red, green, blue}, 32'h666666);
    end

    // Horizontal wrap with scroll_x = 300
    applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 10'd300, 10'd0, 1'b0, '0, 24'h0);
    applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, '0, 24'h0);
    pixelStep(1'b1, 10'd80, 10'd0, 1'b1);
    pixelStep(1'b1, 10'd80, 10'd0, 1'b1);
    checkOutput("wrap_addr", 32'(mem_addr), 32'd20);

    // Illegal scroll write ignored; write coincident with frame_start takes effect
    applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 10'd320, 10'd0, 1'b0, '0, 24'h0);
    applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, '0, 24'h0);
    pixelStep(1'b1, 10'd80, 10'd0, 1'b1);
    pixelStep(1'b1, 10'd80, 10'd0, 1'b1);
    checkOutput("illegal_scroll_ignored", 32'(mem_addr), 32'd20);
    applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 10'd7, 10'd0, 1'b0, '0, 24'h0);
    pixelStep(1'b1, 10'd0, 10'd0, 1'b1);
    pixelStep(1'b1, 10'd0, 10'd0, 1'b1);
    checkOutput("same_cycle_scroll", 32'(mem_addr), 32'd7);

    // Blanked and out-of-range pixels
    repeat (4) pixelStep(1'b1, 10'd10, 10'd10, 1'b0);
    checkOutput("blank_valid", 32'(pix_valid), 32'd0);
    checkOutput("blank_rgb", {8'h0, red, green, blue}, 32'h0);
    repeat (4) pixelStep(1'b1, 10'd10, 10'd480, 1'b1);
    checkOutput("oor_valid", 32'(pix_valid), 32'd0);
    checkOutput("oor_rgb", {8'h0, red, green, blue}, 32'h0);

    // Reset palette then overwrite entry 15
    force_mem = 1'b1; force_val = 4'd15;
    applyStimulus(1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, '0, 24'h0);
    repeat (4) pixelStep(1'b1, 10'd0, 10'd0, 1'b1);
    checkOutput("pal15_reset", {8'h0, red, green, blue}, 32'hFFFFFF);
    checkOutput("pal15_valid", 32'(pix_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 4'd15,
                  24'h00FF00);
    repeat (4) pixelStep(1'b1, 10'd0, 10'd0, 1'b1);
    checkOutput("pal15_written", {8'h0, red, green, blue}, 32'h00FF00);
    force_mem = 1'b0;

    // Reset pulse mid-line with toggling pix_en
    for (int c = 0; c < 24; c++) begin
      if (c == 9) begin
        applyStimulus(1'b1, 1'b1, 10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0,
                      1'b0, '0, 24'h0);
        checkOutput("midline_reset_valid", 32'(pix_valid), 32'd0);
        checkOutput("midline_reset_rgb", {8'h0, red, green, blue}, 32'h0);
      end else begin
        pixelStep(1'($urandom_range(0, 1)), 10'(100 + c), 10'd50, 1'b1);
      end
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic rst, fs, swe, pwe;
      rst = ($urandom_range(0, 499) == 0);
      fs  = ($urandom_range(0, 99) == 0);
      swe = ($urandom_range(0, 29) == 0);
      pwe = ($urandom_range(0, 19) == 0);
      applyStimulus(rst, 1'($urandom_range(0, 3) != 0), 10'($urandom_range(0, 1023)),
                    10'($urandom_range(0, 600)), 1'($urandom_range(0, 4) != 0), fs, swe,
                    10'($urandom_range(0, 400)), 10'($urandom_range(0, 300)), pwe,
                    IDX_W'($urandom_range(0, PAL_N - 1)), 24'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
